// File: rtl/lsu_data_if.sv
// rtl/lsu_data_if.sv - load/store adapter between the core memory stage and a word-wide data_mem
// Sub-word stores go through read-modify-write because data_mem has no byte enables.
module lsu_data_if #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wd_i,
    output logic [31:0]       core_rd_o,
    output logic              core_stall_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wd_o,
    output logic              mem_we_o,
    input  logic [31:0]       mem_rd_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_WAIT,
        S_RMW_READ,
        S_RMW_WRITE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_size;
    logic [15:0]       r_data;
    logic [31:0]       r_merge;

    logic        w_idle;
    logic        w_size_ok;
    logic        w_align_bad;
    logic        w_err;
    logic        w_accept;
    logic        w_sw;
    logic        w_rmw;
    logic        w_load;
    logic [4:0]  w_byte_sh;
    logic [4:0]  w_half_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merge;

    assign w_idle = (r_state == S_IDLE);

    always_comb begin
        w_size_ok = 1'b0;
        if (core_we_i) begin
            w_size_ok = (core_size_i == 3'b000) || (core_size_i == 3'b001) ||
                        (core_size_i == 3'b010);
        end else begin
            w_size_ok = (core_size_i == 3'b000) || (core_size_i == 3'b001) ||
                        (core_size_i == 3'b010) || (core_size_i == 3'b100) ||
                        (core_size_i == 3'b101);
        end
    end

    assign w_align_bad = ((core_size_i[1:0] == 2'b10) && (core_addr_i[1:0] != 2'b00)) ||
                         ((core_size_i[1:0] == 2'b01) && core_addr_i[0]);
    assign w_err    = w_idle && core_req_i && (!w_size_ok || w_align_bad);
    assign w_accept = w_idle && core_req_i && !w_err;
    assign w_sw     = w_accept && core_we_i && (core_size_i == 3'b010);
    assign w_rmw    = w_accept && core_we_i && (core_size_i != 3'b010);
    assign w_load   = w_accept && !core_we_i;

    // Lane positions come from the latched offset; core_* may already have moved on.
    assign w_byte_sh = {r_addr[1:0], 3'b000};
    assign w_half_sh = {r_addr[1], 4'b0000};
    assign w_byte    = mem_rd_i[w_byte_sh +: 8];
    assign w_half    = mem_rd_i[w_half_sh +: 16];

    always_comb begin
        w_load_data = mem_rd_i;
        case (r_size)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = mem_rd_i;
        endcase
    end

    always_comb begin
        w_merge = mem_rd_i;
        if (r_size[1:0] == 2'b00) begin
            w_merge[w_byte_sh +: 8] = r_data[7:0];
        end else begin
            w_merge[w_half_sh +: 16] = r_data;
        end
    end

    // Strobes are forced low while reset is held so no partial write can escape.
    always_comb begin
        core_stall_o = rst_n && ((w_load || w_rmw) || (r_state == S_RMW_READ));
        mem_we_o     = rst_n && (w_sw || (r_state == S_RMW_WRITE));
        err_o        = rst_n && w_err;
        mem_wd_o     = w_idle ? core_wd_i : r_merge;
        mem_addr_o   = w_idle ? {core_addr_i[ADDR_W-1:2], 2'b00} : {r_addr[ADDR_W-1:2], 2'b00};
        core_rd_o    = (r_state == S_LOAD_WAIT) ? w_load_data : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_size  <= 3'd0;
            r_data  <= 16'd0;
            r_merge <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load || w_rmw) begin
                        r_addr  <= core_addr_i;
                        r_size  <= core_size_i;
                        r_data  <= core_wd_i[15:0];
                        r_state <= w_load ? S_LOAD_WAIT : S_RMW_READ;
                    end
                end
                S_LOAD_WAIT: r_state <= S_IDLE;
                S_RMW_READ: begin
                    r_merge <= w_merge;
                    r_state <= S_RMW_WRITE;
                end
                S_RMW_WRITE: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_data_if.sv
// tb/tb_lsu_data_if.sv - directed and random checks of lsu_data_if against a byte-array memory model
module tb_lsu_data_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        err_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic        mem_we_o;
    logic [31:0] mem_rd;

    logic [31:0] dmem [0:63];
    logic [7:0]  ref_mem [0:255];

    int total = 0;
    int bad   = 0;
    logic [31:0] last_rd;
    logic [31:0] last_wd;
    int          last_stalls;

    lsu_data_if #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_size_i  (core_size),
        .core_addr_i  (core_addr),
        .core_wd_i    (core_wd),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .err_o        (err_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_we_o     (mem_we_o),
        .mem_rd_i     (mem_rd)
    );

    always #5 clk = ~clk;

    // data_mem: synchronous write, registered read, aliased onto 256 bytes
    always @(posedge clk) begin
        if (mem_we_o) dmem[mem_addr_o[7:2]] <= mem_wd_o;
        mem_rd <= dmem[mem_addr_o[7:2]];
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic we, input logic [2:0] sz, input logic [1:0] a);
        if (we && sz > 3'd2) return 1'b1;
        if (!we && (sz == 3'd3 || sz == 3'd6 || sz == 3'd7)) return 1'b1;
        if (sz == 3'd2 && a != 2'd0) return 1'b1;
        if ((sz == 3'd1 || sz == 3'd5) && a[0]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [7:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = ref_mem[a];
        h = {ref_mem[a + 8'd1], ref_mem[a]};
        case (sz)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'd0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'd0, h};
            default: return ref_word(a);
        endcase
    endfunction

    task automatic model_store(input logic [2:0] sz, input logic [7:0] a, input logic [31:0] wd);
        ref_mem[a] = wd[7:0];
        if (sz != 3'd0) ref_mem[a + 8'd1] = wd[15:8];
        if (sz == 3'd2) begin
            ref_mem[a + 8'd2] = wd[23:16];
            ref_mem[a + 8'd3] = wd[31:24];
        end
    endtask

    // Entered and left at posedge+1; holds inputs while stalled.
    task automatic do_req(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd);
        logic        e_err;
        int          e_stall;
        logic [31:0] e_rd;
        int          stalls;
        logic        done;
        logic        f_err;
        logic        f_we;
        logic [31:0] f_rd;
        logic [31:0] f_addr;
        logic [31:0] f_wd;
        e_err   = model_err(we, sz, addr[1:0]);
        e_stall = e_err ? 0 : (!we ? 1 : ((sz == 3'd2) ? 0 : 2));
        e_rd    = (e_err || we) ? 32'd0 : model_load(sz, addr[7:0]);
        core_req = 1'b1; core_we = we; core_size = sz; core_addr = addr; core_wd = wd;
        stalls = 0; done = 1'b0;
        f_err = 1'b0; f_we = 1'b0; f_rd = '0; f_addr = '0; f_wd = '0;
        for (int c = 0; c < 6 && !done; c++) begin
            @(negedge clk);
            if (core_stall_o) stalls++;
            else begin
                done = 1'b1;
                f_err = err_o; f_we = mem_we_o; f_rd = core_rd_o;
                f_addr = mem_addr_o; f_wd = mem_wd_o;
            end
            @(posedge clk); #1;
        end
        core_req = 1'b0;
        if (!e_err && we) model_store(sz, addr[7:0], wd);
        chk("complete", 32'(done), 32'd1);
        chk("stall_cycles", 32'(stalls), 32'(e_stall));
        chk("err", 32'(f_err), 32'(e_err));
        chk("mem_we", 32'(f_we), 32'(!e_err && we));
        chk("core_rd", f_rd, e_rd);
        if (!e_err && we) begin
            chk("mem_addr", f_addr, {addr[31:2], 2'b00});
            chk("mem_wd", f_wd, ref_word(addr[7:0]));
        end
        last_rd = f_rd; last_wd = f_wd; last_stalls = stalls;
    endtask

    initial begin
        logic        we;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [2:0]  ld_sizes [0:4];
        ld_sizes[0] = 3'd0; ld_sizes[1] = 3'd1; ld_sizes[2] = 3'd2;
        ld_sizes[3] = 3'd4; ld_sizes[4] = 3'd5;

        rst_n = 1'b0;
        core_req = 1'b1; core_we = 1'b1; core_size = 3'd2; core_addr = 32'h20; core_wd = 32'h1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_we", 32'(mem_we_o), 32'd0);
        chk("reset_stall", 32'(core_stall_o), 32'd0);
        chk("reset_err", 32'(err_o), 32'd0);
        chk("reset_rd", core_rd_o, 32'd0);
        core_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 64; i++) do_req(1'b1, 3'd2, 32'(i * 4), $urandom);

        // reset while an SB is between its read and write
        core_req = 1'b1; core_we = 1'b1; core_size = 3'd0; core_addr = 32'h10; core_wd = 32'hA5;
        @(negedge clk);
        chk("sb_idle_stall", 32'(core_stall_o), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rmw_read_stall", 32'(core_stall_o), 32'd1);
        chk("rmw_read_we", 32'(mem_we_o), 32'd0);
        rst_n = 1'b0; core_req = 1'b0;
        #1;
        chk("mid_rmw_reset_stall", 32'(core_stall_o), 32'd0);
        chk("mid_rmw_reset_we", 32'(mem_we_o), 32'd0);
        @(negedge clk);
        chk("post_reset_we", 32'(mem_we_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mem10_unchanged", dmem[4], ref_word(8'h10));
        do_req(1'b0, 3'd2, 32'h10, 32'd0);

        do_req(1'b1, 3'd2, 32'h20, 32'hDEADBEEF);
        chk("sw_wd", last_wd, 32'hDEADBEEF);
        chk("sw_stalls", 32'(last_stalls), 32'd0);
        do_req(1'b0, 3'd2, 32'h20, 32'd0);
        chk("lw_20", last_rd, 32'hDEADBEEF);
        chk("lw_stalls", 32'(last_stalls), 32'd1);
        do_req(1'b0, 3'd0, 32'h23, 32'd0); chk("lb_23", last_rd, 32'hFFFFFFDE);
        do_req(1'b0, 3'd4, 32'h23, 32'd0); chk("lbu_23", last_rd, 32'h000000DE);
        do_req(1'b0, 3'd1, 32'h22, 32'd0); chk("lh_22", last_rd, 32'hFFFFDEAD);
        do_req(1'b0, 3'd5, 32'h20, 32'd0); chk("lhu_20", last_rd, 32'h0000BEEF);
        do_req(1'b0, 3'd0, 32'h21, 32'd0); chk("lb_21", last_rd, 32'hFFFFFFBE);

        do_req(1'b1, 3'd2, 32'h30, 32'h11223344);
        do_req(1'b1, 3'd0, 32'h31, 32'hFFFFFFA5);
        chk("sb_merge", last_wd, 32'h1122A544);
        chk("sb_stalls", 32'(last_stalls), 32'd2);
        do_req(1'b1, 3'd1, 32'h32, 32'h12345A5A);
        chk("sh_merge", last_wd, 32'h5A5AA544);
        do_req(1'b0, 3'd2, 32'h30, 32'd0);
        chk("lw_30", last_rd, 32'h5A5AA544);

        do_req(1'b0, 3'd2, 32'h21, 32'd0);
        do_req(1'b1, 3'd2, 32'h22, 32'hCAFEF00D);
        do_req(1'b0, 3'd1, 32'h23, 32'd0);
        do_req(1'b1, 3'd1, 32'h41, 32'h0000BEEF);
        do_req(1'b0, 3'd3, 32'h20, 32'd0);
        do_req(1'b1, 3'd4, 32'h20, 32'h77777777);
        chk("err_mem20", dmem[8], 32'hDEADBEEF);
        chk("err_mem40", dmem[16], ref_word(8'h40));

        for (int n = 0; n < 1000; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) sz = 3'($urandom_range(0, 7));
            else if (we) sz = 3'($urandom_range(0, 2));
            else sz = ld_sizes[$urandom_range(0, 4)];
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz[1:0] == 2'b10) addr[1:0] = 2'b00;
                else if (sz[1:0] == 2'b01) addr[0] = 1'b0;
            end
            do_req(we, sz, addr, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        for (int i = 0; i < 64; i++) chk("final_image", dmem[i], ref_word(8'(i * 4)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
